// File: rtl/dsp_file_arbiter.sv
// Round-robin arbiter that gives four requesters turns on one shared file port.
// Build option DSP_FILE_ARB_TIMEOUT_EN aborts a grant that never sees file_active.
module dsp_file_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  input  logic [31:0]  req_file_num,
  input  logic [3:0]   req_file_read,
  input  logic [3:0]   req_file_write,
  input  logic [127:0] req_file_write_data,
  output logic [3:0]   req_file_active,
  output logic [31:0]  req_file_read_data,
  output logic [3:0]   grant,
  output logic [7:0]   file_num,
  output logic         file_read,
  output logic         file_write,
  output logic [31:0]  file_write_data,
  input  logic [31:0]  file_read_data,
  input  logic         file_active,
  output logic         error
);

  // state   | meaning
  // IDLE    | no owner, next request is arbitrated
  // GRANTED | owner chosen, waiting for the first file_active
  // ACTIVE  | file port busy for the owner
  // RELEASE | one dead cycle before the next arbitration
  typedef enum logic [1:0] {IDLE, GRANTED, ACTIVE, RELEASE} state_t;

  state_t      state;
  logic [1:0]  owner;
  logic [1:0]  last_owner;
  logic [1:0]  pick;
  logic [1:0]  sel;
  logic [3:0]  req;
  logic [7:0]  sel_num;
  logic [31:0] sel_data;
  logic        sel_rd;
  logic        sel_wr;

`ifdef DSP_FILE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`endif

  assign req                = req_file_read | req_file_write;
  assign req_file_active    = grant & {4{file_active}};
  assign req_file_read_data = file_read_data;

  // Search upward from the previous owner so nobody can hog the port.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = last_owner + 2'd1;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_owner + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign sel      = (state == IDLE) ? pick : owner;
  assign sel_num  = req_file_num[{sel, 3'b000} +: 8];
  assign sel_data = req_file_write_data[{sel, 5'b00000} +: 32];
  assign sel_rd   = req_file_read[sel];
  assign sel_wr   = req_file_write[sel];

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state           <= IDLE;
      owner           <= 2'd0;
      last_owner      <= 2'd3;
      grant           <= 4'd0;
      file_num        <= 8'd0;
      file_read       <= 1'b0;
      file_write      <= 1'b0;
      file_write_data <= 32'd0;
      error           <= 1'b0;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
      cnt             <= '0;
`endif
    end else begin
      // Default: port mirrors the selected requester, write wins a conflict.
      file_num        <= sel_num;
      file_read       <= sel_rd & ~sel_wr;
      file_write      <= sel_wr;
      file_write_data <= sel_data;
      if (sel_rd && sel_wr && (state != RELEASE) && (state != IDLE || req != 4'd0))
        error <= 1'b1;
      case (state)
        IDLE: begin
          if (file_active) error <= 1'b1;
          if (req != 4'd0) begin
            owner <= pick;
            grant <= 4'b0001 << pick;
            state <= GRANTED;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else begin
            file_num        <= 8'd0;
            file_read       <= 1'b0;
            file_write      <= 1'b0;
            file_write_data <= 32'd0;
          end
        end
        GRANTED: begin
          if (file_active) begin
            state <= ACTIVE;
`ifdef DSP_FILE_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else if (!sel_rd && !sel_wr) begin
            state <= RELEASE;
          end
`ifdef DSP_FILE_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            error <= 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ACTIVE: begin
          if (!file_active && !sel_rd && !sel_wr) state <= RELEASE;
        end
        default: begin
          last_owner <= owner;
          state      <= IDLE;
        end
      endcase
      if ((state == GRANTED || state == ACTIVE) && !file_active && !sel_rd && !sel_wr
`ifdef DSP_FILE_ARB_TIMEOUT_EN
          || (state == GRANTED && !file_active && cnt == CW'(TIMEOUT_CYCLES - 1))
`endif
          || state == RELEASE) begin
        grant           <= 4'd0;
        file_num        <= 8'd0;
        file_read       <= 1'b0;
        file_write      <= 1'b0;
        file_write_data <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_file_arbiter.sv
// Directed-vector bench for dsp_file_arbiter; timeout case runs only when
// DSP_FILE_ARB_TIMEOUT_EN is defined.
module tb_dsp_file_arbiter;

  logic         wb_clk = 1'b0;
  logic         wb_rst;
  logic [31:0]  req_file_num;
  logic [3:0]   req_file_read;
  logic [3:0]   req_file_write;
  logic [127:0] req_file_write_data;
  logic [3:0]   req_file_active;
  logic [31:0]  req_file_read_data;
  logic [3:0]   grant;
  logic [7:0]   file_num;
  logic         file_read;
  logic         file_write;
  logic [31:0]  file_write_data;
  logic [31:0]  file_read_data;
  logic         file_active;
  logic         error;

  int n_vec  = 0;
  int n_miss = 0;

  dsp_file_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .req_file_num(req_file_num), .req_file_read(req_file_read),
    .req_file_write(req_file_write), .req_file_write_data(req_file_write_data),
    .req_file_active(req_file_active), .req_file_read_data(req_file_read_data),
    .grant(grant), .file_num(file_num), .file_read(file_read),
    .file_write(file_write), .file_write_data(file_write_data),
    .file_read_data(file_read_data), .file_active(file_active), .error(error)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    wb_rst              = 1'b1;
    req_file_num        = '0;
    req_file_read       = '0;
    req_file_write      = '0;
    req_file_write_data = '0;
    file_read_data      = '0;
    file_active         = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b0;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    do_reset();
    check_vec("rst_grant", grant, 0);
    check_vec("rst_error", error, 0);
    check_vec("rst_port", {file_num, file_read, file_write}, 0);
    check_vec("rst_wdata", file_write_data, 0);

    // single read by requester 2
    req_file_num[23:16] = 8'h05;
    req_file_read[2]    = 1'b1;
    @(negedge wb_clk);
    check_vec("rd_grant", grant, 4'b0100);
    check_vec("rd_num", file_num, 8'h05);
    check_vec("rd_read", file_read, 1);
    file_active    = 1'b1;
    file_read_data = 32'h1234_5678;
    #1;
    check_vec("rd_active", req_file_active, 4'b0100);
    check_vec("rd_rdata", req_file_read_data, 32'h1234_5678);
    @(negedge wb_clk);
    @(negedge wb_clk);
    @(negedge wb_clk);
    file_active   = 1'b0;
    req_file_read = '0;
    @(negedge wb_clk);
    check_vec("rd_rel_grant", grant, 0);
    check_vec("rd_rel_read", file_read, 0);
    @(negedge wb_clk);
    check_vec("rd_idle_grant", grant, 0);
    check_vec("rd_error", error, 0);

    // round robin
    do_reset();
    req_file_read = 4'hF;
    @(negedge wb_clk);
    for (int i = 0; i < 5; i++) begin
      check_vec($sformatf("rr_grant%0d", i), grant, rr_exp[i]);
      file_active = 1'b1;
      @(negedge wb_clk);
      file_active   = 1'b0;
      req_file_read = 4'hF & ~rr_exp[i];
      @(negedge wb_clk);
      check_vec($sformatf("rr_gap%0d", i), grant, 0);
      req_file_read = 4'hF;
      @(negedge wb_clk);
      @(negedge wb_clk);
    end

    // write conflict by requester 1
    do_reset();
    req_file_read[1]            = 1'b1;
    req_file_write[1]           = 1'b1;
    req_file_write_data[63:32]  = 32'hDEAD_BEEF;
    @(negedge wb_clk);
    check_vec("wc_grant", grant, 4'b0010);
    check_vec("wc_write", file_write, 1);
    check_vec("wc_read", file_read, 0);
    check_vec("wc_data", file_write_data, 32'hDEAD_BEEF);
    check_vec("wc_error", error, 1);

    // owner drops request while GRANTED
    do_reset();
    req_file_read[0] = 1'b1;
    @(negedge wb_clk);
    check_vec("drop_grant", grant, 4'b0001);
    req_file_read = '0;
    @(negedge wb_clk);
    check_vec("drop_rel", grant, 0);
    check_vec("drop_error", error, 0);

    // reset while requester 3 is active
    do_reset();
    req_file_read[3] = 1'b1;
    @(negedge wb_clk);
    check_vec("ra_grant", grant, 4'b1000);
    file_active = 1'b1;
    @(negedge wb_clk);
    check_vec("ra_active", req_file_active, 4'b1000);
    #2 wb_rst = 1'b1;
    #1;
    check_vec("ra_rst_grant", grant, 0);
    check_vec("ra_rst_read", file_read, 0);
    check_vec("ra_rst_active", req_file_active, 0);
    @(negedge wb_clk);
    wb_rst        = 1'b0;
    file_active   = 1'b0;
    req_file_read = 4'b1001;
    @(negedge wb_clk);
    check_vec("ra_next_grant", grant, 4'b0001);

    // spurious file_active in IDLE
    do_reset();
    file_active = 1'b1;
    #1;
    check_vec("sp_route", req_file_active, 0);
    @(negedge wb_clk);
    check_vec("sp_error", error, 1);
    file_active = 1'b0;
    @(negedge wb_clk);
    check_vec("sp_sticky", error, 1);

`ifdef DSP_FILE_ARB_TIMEOUT_EN
    do_reset();
    req_file_read = 4'b0011;
    @(negedge wb_clk);
    check_vec("to_grant", grant, 4'b0001);
    repeat (7) @(negedge wb_clk);
    check_vec("to_early", error, 0);
    @(negedge wb_clk);
    check_vec("to_error", error, 1);
    check_vec("to_rel", grant, 0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    check_vec("to_next", grant, 4'b0010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dsp_file_arbiter.md
DSP_FILE_ARBITER -- requirements
Module: dsp_file_arbiter

Interface
REQ-001 Clocking SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the cycles allowed from grant to first file_active before abort.
REQ-003 wb_clk  input  1  sole clock, rising edge.
REQ-004 wb_rst  input  1  asynchronous active-high reset.
REQ-005 req_file_num  input  32  four packed 8-bit file numbers; requester n uses bits [8n+7:8n].
REQ-006 req_file_read  input  4  per-requester read request, level.
REQ-007 req_file_write  input  4  per-requester write request, level.
REQ-008 req_file_write_data  input  128  four packed 32-bit write words.
REQ-009 req_file_active  output  4  file_active routed to the owner only; 0 for all others.
REQ-010 req_file_read_data  output  32  file_read_data broadcast to all requesters.
REQ-011 grant  output  4  one-hot owner indication; all zero when idle.
REQ-012 file_num, file_read, file_write, file_write_data  output  8/1/1/32  shared file port.
REQ-013 file_read_data, file_active  input  32/1  shared file port return.
REQ-014 error  output  1  sticky protocol/timeout flag.

Function
REQ-015 The FSM SHALL have the states IDLE, GRANTED, ACTIVE and RELEASE.
REQ-016 In IDLE, when any requester has read or write asserted, the arbiter SHALL select one round-robin, searching from last_owner+1 upward mod 4, set grant one-hot on the next edge and enter GRANTED.
REQ-017 While grant is nonzero, file_num, file_read, file_write and file_write_data SHALL be registered copies of the owner's inputs, so the port lags the owner by 1 cycle; when idle they SHALL be 0.
REQ-018 GRANTED SHALL go to ACTIVE on the first cycle file_active=1.
REQ-019 ACTIVE SHALL go to RELEASE when file_active=0 and the owner's read and write are both 0.
REQ-020 RELEASE SHALL last exactly 1 cycle with grant=0 and file_read=file_write=0, update last_owner to the released owner, and return to IDLE.
REQ-021 Minimum grant-to-grant spacing SHALL be 2 cycles (RELEASE plus IDLE), so a single requester cannot starve the others.
REQ-022 Requests from non-owners SHALL be ignored (no queueing) until IDLE.
REQ-023 If the owner asserts read and write together, write SHALL win, file_read SHALL be forced to 0, and error SHALL be set.
REQ-024 If the owner drops read and write while in GRANTED, the arbiter SHALL go to RELEASE without setting error.
REQ-025 file_active=1 while in IDLE SHALL set error and SHALL NOT be routed to any requester.
REQ-026 error SHALL clear only on reset.

Reset
REQ-027 Asserting wb_rst, at any time including mid-transaction, SHALL immediately force grant=0, req_file_active=0, all file port outputs to 0, error=0, last_owner=3 (so requester 0 is first), and state IDLE.
REQ-028 After reset deasserts, the first arbitration SHALL occur on the first rising edge that sees a request.

Configuration
REQ-029 The macro DSP_FILE_ARB_TIMEOUT_EN SHALL control the grant timeout.
REQ-030 With DSP_FILE_ARB_TIMEOUT_EN defined: a counter SHALL start at grant; if it reaches TIMEOUT_CYCLES in GRANTED, the arbiter SHALL set error and go to RELEASE (forcing file_read/file_write to 0); the counter SHALL clear in ACTIVE.
REQ-031 Without DSP_FILE_ARB_TIMEOUT_EN: there SHALL be no counter, and GRANTED SHALL wait indefinitely.

Verification
REQ-032 Single read: requester 2 raises read with file 0x05 and file_active pulses 3 cycles -> grant=0100 one edge later, file_num=0x05, only req_file_active[2] toggles, then RELEASE then IDLE, error=0.
REQ-033 Round-robin: all four hold read continuously -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-034 Write conflict: owner 1 asserts read and write with data 0xDEADBEEF -> file_write=1, file_read=0, file_write_data=0xDEADBEEF, error=1.
REQ-035 Reset mid-ACTIVE: wb_rst asserted while owner 3 is active -> grant, file_read and req_file_active all 0 with no clock edge; next request from 3 and 0 together grants 0.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=8): grant to 0 with file_active held low -> error=1 after 8 cycles, then RELEASE, and the next pending requester 1 is granted.
REQ-037 Spurious file_active: file_active=1 while IDLE -> error=1 and req_file_active=0000.
